alu_seq: RTL

- Multi-precision sequencer for the 8-bit ALU: runs an N-byte operation, little-endian (LSB byte first), on operands held in the shared data RAM.
- Per byte: fetches A[i] and B[i], drives the ALU, writes R[i] back, and propagates carry/borrow between bytes.
- Sits between the control unit, which issues start, and the ALU plus RAM; it is the sole master of the ALU/RAM ports while busy.

---
 rtl/alu_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Multi-precision byte sequencer: runs an N-byte ALU operation on RAM operands,
// LSB byte first, carrying/borrowing between bytes.
module alu_seq #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_r,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic              cy_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_ci,
    input  logic [7:0]        alu_out,
    input  logic              alu_cy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_EXEC,
        S_DONE
    } state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [ADDR_W-1:0] base_r_q;
    logic              c;
    logic [7:0]        a_reg;
    logic [8:0]        sub_rhs;
    logic              c_next;
    logic              last_byte;

    // The ALU reports no borrow, so subtract borrow is derived here.
    always_comb begin
        sub_rhs   = {1'b0, mem_rdata} + 9'(c);
        last_byte = (idx == len_q - LEN_W'(1));
        case (op_q)
            3'b000:  c_next = alu_cy;
            3'b001:  c_next = ({1'b0, a_reg} < sub_rhs);
            default: c_next = 1'b0;
        endcase
    end

    // RAM/ALU ports are decoded from state; reset masks them so an in-flight write is dropped.
    always_comb begin
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        alu_ci    = 1'b0;
        if (!rst) begin
            case (state)
                S_RD_A: begin
                    mem_addr = base_a_q + ADDR_W'(idx);
                    mem_re   = 1'b1;
                end
                S_RD_B: begin
                    mem_addr = base_b_q + ADDR_W'(idx);
                    mem_re   = 1'b1;
                end
                S_EXEC: begin
                    alu_a     = a_reg;
                    alu_b     = mem_rdata;
                    alu_op    = op_q;
                    alu_ci    = (op_q == 3'b000 || op_q == 3'b001) ? c : 1'b0;
                    mem_addr  = base_r_q + ADDR_W'(idx);
                    mem_we    = 1'b1;
                    mem_wdata = alu_out;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cy_out   <= 1'b0;
            idx      <= '0;
            op_q     <= '0;
            len_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_r_q <= '0;
            c        <= 1'b0;
            a_reg    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        len_q    <= len;
                        base_a_q <= base_a;
                        base_b_q <= base_b;
                        base_r_q <= base_r;
                        c        <= cin;
                        idx      <= '0;
                        if (len == '0) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            cy_out <= cin;
                        end else begin
                            state <= S_RD_A;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RD_A: state <= S_RD_B;
                S_RD_B: begin
                    a_reg <= mem_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    c <= c_next;
                    if (last_byte) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        cy_out <= c_next;
                    end else begin
                        idx   <= idx + LEN_W'(1);
                        state <= S_RD_A;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
